// File: rtl/axi_stb_pkg.sv
// Shared types and constants for the AXI read-channel forwarder.
// FSM state encoding, response codes and small helpers.
package axi_stb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD_AR = 2'd1,
    FWD_R  = 2'd2,
    ERR_R  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  function automatic logic cnt_is_len(
    input logic [8:0] cnt,
    input logic [7:0] len
  );
    return cnt == {1'b0, len};
  endfunction

endpackage

// File: rtl/axi_ldb_fifo.sv
// Small synchronous FIFO with first-word-fallthrough output.
// Flush empties it in one cycle; storage itself is not reset.
module axi_ldb_fifo #(
  parameter int W     = 130,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // beat storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/axi_ldb_s.sv
// AXI read-channel forwarder: one AR in flight, R beats buffered,
// local SLVERR beats when the downstream stalls past TIMEOUT.
module axi_ldb_s
  import axi_stb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  proto_err
);

  localparam int FW = DATA_WIDTH + 2;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] W_LIM = WW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_alive;
  logic [7:0]    r_arlen;
  logic [8:0]    r_beat;
  logic [8:0]    r_push;
  logic [WW-1:0] r_wait;

  logic [FW-1:0] w_fifo_q;
  logic          w_full;
  logic          w_empty;
  logic          w_uhs;
  logic          w_pop;
  logic          w_done;
  logic          w_dn_hs;
  logic          w_push_ok;
  logic          w_push;
  logic          w_stray;
  logic          w_bad_last;
  logic          w_wait_max;

  assign busy      = (r_state != IDLE);
  assign s_arready = (r_state == IDLE) && r_alive;
  assign m_arlen   = r_arlen;

  // downstream ready: open in IDLE to drop strays, backpressure in FWD_R
  always_comb begin
    m_rready = 1'b0;
    unique case (r_state)
      IDLE:    m_rready = r_alive;
      FWD_R:   m_rready = !w_full;
      default: m_rready = 1'b0;
    endcase
  end

  assign s_rvalid = ((r_state == FWD_R) && !w_empty) ||
                    (r_state == ERR_R);
  assign s_rdata  = w_empty ? '0 : w_fifo_q[FW-1:2];
  assign s_rresp  = !w_empty ? w_fifo_q[1:0] :
                    (r_state == ERR_R) ? RESP_SLVERR : RESP_OKAY;
  assign s_rlast  = s_rvalid && cnt_is_len(r_beat, r_arlen);

  assign w_uhs      = s_rvalid && s_rready;
  assign w_pop      = w_uhs && !w_empty;
  assign w_done     = w_uhs && s_rlast;
  assign w_dn_hs    = m_rvalid && m_rready;
  assign w_push_ok  = (r_push <= {1'b0, r_arlen});
  assign w_push     = (r_state == FWD_R) && w_dn_hs && w_push_ok;
  assign w_stray    = w_dn_hs && !w_push;
  assign w_bad_last = w_push && (m_rlast != cnt_is_len(r_push, r_arlen));
  assign w_wait_max = (r_wait == W_LIM);

  axi_ldb_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_done),
    .i_push  (w_push),
    .i_data  ({m_rdata, m_rresp}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // transaction FSM with counters, AR copy and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_alive     <= 1'b0;
      r_arlen     <= '0;
      r_beat      <= '0;
      r_push      <= '0;
      r_wait      <= '0;
      m_arvalid   <= 1'b0;
      m_araddr    <= '0;
      m_arsize    <= '0;
      m_arburst   <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_stray || w_bad_last) proto_err <= 1'b1;
      if (w_push) r_push <= r_push + 9'd1;
      if (w_uhs)  r_beat <= r_beat + 9'd1;
      unique case (r_state)
        IDLE: begin
          if (s_arvalid && s_arready) begin
            m_araddr  <= s_araddr;
            r_arlen   <= s_arlen;
            m_arsize  <= s_arsize;
            m_arburst <= s_arburst;
            m_arvalid <= 1'b1;
            r_beat    <= '0;
            r_push    <= '0;
            r_wait    <= '0;
            r_state   <= FWD_AR;
          end
        end
        FWD_AR: begin
          if (m_arvalid && m_arready) begin
            m_arvalid <= 1'b0;
            r_wait    <= '0;
            r_state   <= FWD_R;
          end else if (w_wait_max) begin
            m_arvalid   <= 1'b0;
            timeout_err <= 1'b1;
            r_beat      <= '0;
            r_state     <= ERR_R;
          end else begin
            r_wait <= (&r_wait) ? r_wait : r_wait + 1'b1;
          end
        end
        FWD_R: begin
          if (w_done) begin
            r_state <= IDLE;
          end else if (w_push) begin
            r_wait <= '0;
          end else if (w_push_ok) begin
            if (w_wait_max) begin
              timeout_err <= 1'b1;
              r_state     <= ERR_R;
            end else begin
              r_wait <= (&r_wait) ? r_wait : r_wait + 1'b1;
            end
          end
        end
        ERR_R: begin
          if (w_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
